// File: rtl/conv_8x32_idx_seq.sv
// Index sequencer for the 8x32 convolutional coprocessor.
// Walks every (n, k) pair of a full linear convolution and drives MAC strobes.
module conv_8x32_comp_eq #(
    parameter int DATA_WIDTH = 6
) (
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  d_out
);
    assign d_out = (a_in == b_in);
endmodule

module conv_8x32_idx_seq #(
    parameter int IDX_WIDTH  = 6,
    parameter int KERNEL_MAX = 8,
    parameter int SIGNAL_MAX = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_in,
    input  logic                 stall_in,
    input  logic [IDX_WIDTH-1:0] kernel_len_in,
    input  logic [IDX_WIDTH-1:0] signal_len_in,
    output logic [IDX_WIDTH-1:0] x_addr_out,
    output logic [IDX_WIDTH-1:0] h_addr_out,
    output logic [IDX_WIDTH-1:0] y_addr_out,
    output logic                 mac_en_out,
    output logic                 acc_clr_out,
    output logic                 acc_wr_out,
    output logic                 busy_out,
    output logic                 done_out
);
    localparam logic [IDX_WIDTH-1:0] KMAX = IDX_WIDTH'(KERNEL_MAX);
    localparam logic [IDX_WIDTH-1:0] LMAX = IDX_WIDTH'(SIGNAL_MAX);
    localparam logic [IDX_WIDTH-1:0] ONE  = IDX_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] TWO  = IDX_WIDTH'(2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] n_q, n_d;
    logic [IDX_WIDTH-1:0] k_q, k_d;
    logic [IDX_WIDTH-1:0] klen_q, klen_d;
    logic [IDX_WIDTH-1:0] llen_q, llen_d;
    logic [IDX_WIDTH-1:0] nlast_q, nlast_d;

    logic [IDX_WIDTH-1:0] k_sat, l_sat, k_term, diff;
    logic                 k_last, n_last, in_range, run, go;

    assign k_sat  = (kernel_len_in > KMAX) ? KMAX : kernel_len_in;
    assign l_sat  = (signal_len_in > LMAX) ? LMAX : signal_len_in;
    assign k_term = klen_q - ONE;

    conv_8x32_comp_eq #(.DATA_WIDTH(IDX_WIDTH)) u_k_eq (
        .a_in  (k_q),
        .b_in  (k_term),
        .d_out (k_last)
    );

    conv_8x32_comp_eq #(.DATA_WIDTH(IDX_WIDTH)) u_n_eq (
        .a_in  (n_q),
        .b_in  (nlast_q),
        .d_out (n_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            k_q     <= '0;
            klen_q  <= '0;
            llen_q  <= '0;
            nlast_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            klen_q  <= klen_d;
            llen_q  <= llen_d;
            nlast_q <= nlast_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        klen_d  = klen_q;
        llen_d  = llen_q;
        nlast_d = nlast_q;
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    klen_d  = k_sat;
                    llen_d  = l_sat;
                    nlast_d = l_sat + k_sat - TWO;
                    n_d     = '0;
                    k_d     = '0;
                    if (k_sat == '0 || l_sat == '0) state_d = DONE;
                    else                            state_d = RUN;
                end
            end
            RUN: begin
                if (!stall_in) begin
                    if (k_last) begin
                        k_d = '0;
                        if (n_last) state_d = DONE;
                        else        n_d = n_q + ONE;
                    end else begin
                        k_d = k_q + ONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // n-k only meaningful once k<=n; the compare guards against wrap
    assign run      = (state_q == RUN);
    assign go       = run & ~stall_in;
    assign diff     = n_q - k_q;
    assign in_range = (k_q <= n_q) && (diff < llen_q);

    assign x_addr_out  = (run && in_range) ? diff : '0;
    assign h_addr_out  = run ? k_q : '0;
    assign y_addr_out  = run ? n_q : '0;
    assign mac_en_out  = go & in_range;
    assign acc_clr_out = go & (k_q == '0);
    assign acc_wr_out  = go & k_last;
    assign busy_out    = run;
    assign done_out    = (state_q == DONE);
endmodule

// File: tb/tb_conv_8x32_idx_seq.sv
// Scoreboard bench for conv_8x32_idx_seq: driver queues expected beats and
// done cycles, a negedge monitor pops and compares.
module tb_conv_8x32_idx_seq;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_in;
    logic         stall_in;
    logic [W-1:0] kernel_len_in;
    logic [W-1:0] signal_len_in;
    logic [W-1:0] x_addr_out;
    logic [W-1:0] h_addr_out;
    logic [W-1:0] y_addr_out;
    logic         mac_en_out;
    logic         acc_clr_out;
    logic         acc_wr_out;
    logic         busy_out;
    logic         done_out;

    conv_8x32_idx_seq dut (
        .clk           (clk),
        .rst           (rst),
        .start_in      (start_in),
        .stall_in      (stall_in),
        .kernel_len_in (kernel_len_in),
        .signal_len_in (signal_len_in),
        .x_addr_out    (x_addr_out),
        .h_addr_out    (h_addr_out),
        .y_addr_out    (y_addr_out),
        .mac_en_out    (mac_en_out),
        .acc_clr_out   (acc_clr_out),
        .acc_wr_out    (acc_wr_out),
        .busy_out      (busy_out),
        .done_out      (done_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x;
        int h;
        int y;
        int mac;
        int clr;
        int wr;
    } beat_t;

    beat_t bq[$];
    int    dq[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    obs_beats, obs_mac, obs_clr, obs_wr;
    bit    mon_en = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_run(input int K, input int L);
        beat_t b;
        for (int n = 0; n <= L + K - 2; n++) begin
            for (int k = 0; k < K; k++) begin
                b.h   = k;
                b.y   = n;
                b.mac = (n - k >= 0 && n - k < L) ? 1 : 0;
                b.x   = b.mac ? n - k : 0;
                b.clr = (k == 0) ? 1 : 0;
                b.wr  = (k == K - 1) ? 1 : 0;
                bq.push_back(b);
            end
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (mon_en) begin
            if (busy_out && !stall_in) begin
                if (bq.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = bq.pop_front();
                    chk("x_addr", x_addr_out, e.x);
                    chk("h_addr", h_addr_out, e.h);
                    chk("y_addr", y_addr_out, e.y);
                    chk("mac_en", mac_en_out, e.mac);
                    chk("acc_clr", acc_clr_out, e.clr);
                    chk("acc_wr", acc_wr_out, e.wr);
                end
                obs_beats++;
                obs_mac += mac_en_out;
                obs_clr += acc_clr_out;
                obs_wr  += acc_wr_out;
            end else if (busy_out) begin
                chk("stall_strobes", {mac_en_out, acc_clr_out, acc_wr_out}, 0);
                if (bq.size() > 0) begin
                    chk("stall_x", x_addr_out, bq[0].x);
                    chk("stall_h", h_addr_out, bq[0].h);
                    chk("stall_y", y_addr_out, bq[0].y);
                end
            end else begin
                chk("idle_outputs", {x_addr_out, h_addr_out, y_addr_out,
                    mac_en_out, acc_clr_out, acc_wr_out}, 0);
            end
            if (done_out) begin
                chk("done_busy", busy_out, 0);
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else                chk("done_cycle", cyc, dq.pop_front());
            end
        end
    end

    task automatic clr_obs();
        obs_beats = 0;
        obs_mac   = 0;
        obs_clr   = 0;
        obs_wr    = 0;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while ((dq.size() != 0 || bq.size() != 0) && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk(nm, dq.size() + bq.size(), 0);
        bq.delete();
        dq.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // K/L are the expected latched lengths; kin/lin are what is driven
    task automatic go(input int kin, input int lin, input int K, input int L,
                      input int st_at, input int st_len,
                      input int mid_at, input bit in_done);
        int B, c0;
        B = (K == 0 || L == 0) ? 0 : (L + K - 1) * K;
        clr_obs();
        if (B > 0) push_run(K, L);
        @(posedge clk); #1;
        start_in      = 1'b1;
        kernel_len_in = W'(kin);
        signal_len_in = W'(lin);
        @(posedge clk); #1;
        start_in      = 1'b0;
        kernel_len_in = '0;
        signal_len_in = '0;
        c0 = cyc;
        dq.push_back(c0 + B + st_len);
        for (int i = 0; i <= B + st_len; i++) begin
            stall_in = (st_len > 0 && i >= st_at && i < st_at + st_len);
            start_in = (mid_at > 0 && i == mid_at) ||
                       (in_done && i == B + st_len);
            signal_len_in = start_in ? W'(9) : '0;
            @(posedge clk); #1;
        end
        stall_in      = 1'b0;
        start_in      = 1'b0;
        signal_len_in = '0;
        drain("run_drain");
    endtask

    initial begin
        rst           = 1'b1;
        start_in      = 1'b0;
        stall_in      = 1'b0;
        kernel_len_in = '0;
        signal_len_in = '0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1;
        @(negedge clk);
        chk("reset_busy", busy_out, 0);
        chk("reset_done", done_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        go(3, 4, 3, 4, 0, 0, 0, 0);
        chk("k3l4_beats", obs_beats, 18);
        chk("k3l4_mac", obs_mac, 12);
        chk("k3l4_wr", obs_wr, 6);
        chk("k3l4_clr", obs_clr, 6);

        go(8, 32, 8, 32, 0, 0, 0, 0);
        chk("k8l32_beats", obs_beats, 312);
        chk("k8l32_mac", obs_mac, 256);
        chk("k8l32_clr", obs_clr, 39);
        chk("k8l32_wr", obs_wr, 39);

        go(3, 4, 3, 4, 7, 5, 0, 0);
        chk("stall_beats", obs_beats, 18);
        chk("stall_mac", obs_mac, 12);

        // abort at beat 10
        clr_obs();
        push_run(8, 32);
        @(posedge clk); #1;
        start_in      = 1'b1;
        kernel_len_in = W'(8);
        signal_len_in = W'(32);
        @(posedge clk); #1;
        start_in      = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bq.delete();
        @(negedge clk);
        chk("abort_busy", busy_out, 0);
        chk("abort_done", done_out, 0);
        chk("abort_beats", obs_beats, 11);
        repeat (5) @(posedge clk);
        #1;
        go(8, 32, 8, 32, 0, 0, 0, 0);
        chk("rerun_beats", obs_beats, 312);
        chk("rerun_mac", obs_mac, 256);

        go(3, 4, 3, 4, 0, 0, 5, 1);
        chk("ign_start_beats", obs_beats, 18);
        chk("ign_start_wr", obs_wr, 6);

        go(0, 5, 0, 5, 0, 0, 0, 0);
        chk("zero_beats", obs_beats, 0);

        go(12, 40, 8, 32, 0, 0, 0, 0);
        chk("sat_beats", obs_beats, 312);
        chk("sat_mac", obs_mac, 256);

        go(1, 1, 1, 1, 0, 0, 0, 0);
        chk("k1l1_beats", obs_beats, 1);
        chk("k1l1_clr", obs_clr, 1);
        chk("k1l1_wr", obs_wr, 1);
        chk("k1l1_mac", obs_mac, 1);

        // rst coincident with start: rst wins
        @(posedge clk); #1;
        rst           = 1'b1;
        start_in      = 1'b1;
        kernel_len_in = W'(3);
        signal_len_in = W'(4);
        @(posedge clk); #1;
        rst      = 1'b0;
        start_in = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", busy_out, 0);
        chk("rst_start_done", done_out, 0);
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
